// File: rtl/sradd_pipe.sv
// sradd_pipe: three-stage single-precision FP adder/subtractor for the FFT butterfly.
// Truncation rounding, no denormals (every non-zero word carries a hidden one),
// underflow flushes to zero, overflow returns the all-ones NaN word.

package sradd_pipe_pkg;

    localparam int unsigned W  = 32;   // word width
    localparam int unsigned EW = 8;    // exponent width
    localparam int unsigned MW = 24;   // mantissa width with hidden one

    // Stage 1 -> stage 2 payload: aligned operands.
    typedef struct packed {
        logic          sign;
        logic          eff_sub;
        logic          bypass;
        logic [W-1:0]  bypass_word;
        logic [EW-1:0] exp_l;
        logic [MW-1:0] man_l;
        logic [MW-1:0] man_s;
    } align_t;

    // Stage 2 -> stage 3 payload: raw sum with carry exponent.
    typedef struct packed {
        logic          sign;
        logic          bypass;
        logic [W-1:0]  bypass_word;
        logic [EW:0]   exp_c;
        logic [MW:0]   sum;
    } add_t;

endpackage

module sradd_pipe
    import sradd_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] z
);

    // Leading-zero count of a 24-bit mantissa field (24 when all zero).
    function automatic logic [4:0] lzc24(input logic [MW-1:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < int'(MW); i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end
        end
        return n;
    endfunction

    logic   en;
    logic   s1_valid;
    logic   s2_valid;
    align_t s1_q;
    align_t s1_next;
    add_t   s2_q;
    add_t   s2_next;
    logic [W-1:0] z_next;

    // Stage 1 working signals
    logic          a_zero;
    logic          b_zero;
    logic          b_sign_eff;
    logic          a_larger;
    logic          sign_l;
    logic          sign_s;
    logic [EW-1:0] exp_l;
    logic [EW-1:0] exp_s;
    logic [EW-1:0] shift;
    logic [MW-1:0] man_l;
    logic [MW-1:0] man_s;

    // Stage 3 working signals
    logic [4:0]    lz;
    logic [MW-2:0] norm_man;
    logic [EW+1:0] exp_dec;
    logic [EW:0]   exp_inc;

    // Whole pipeline advances together unless a finished result is being held.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: detect exact zeros, order operands by magnitude, align the smaller one.
    always_comb begin
        s1_next    = '0;
        b_sign_eff = b[W-1] ^ sub;
        a_zero     = (a == '0);
        b_zero     = (b == '0);
        a_larger   = (a[W-2:0] >= b[W-2:0]);
        sign_l     = a[W-1];
        sign_s     = b_sign_eff;
        exp_l      = a[W-2:MW-1];
        exp_s      = b[W-2:MW-1];
        man_l      = {1'b1, a[MW-2:0]};
        man_s      = {1'b1, b[MW-2:0]};
        if (!a_larger) begin
            sign_l = b_sign_eff;
            sign_s = a[W-1];
            exp_l  = b[W-2:MW-1];
            exp_s  = a[W-2:MW-1];
            man_l  = {1'b1, b[MW-2:0]};
            man_s  = {1'b1, a[MW-2:0]};
        end
        // Shift amounts of 24 and above clear the mantissa entirely.
        shift             = exp_l - exp_s;
        s1_next.sign      = sign_l;
        s1_next.eff_sub   = sign_l ^ sign_s;
        s1_next.exp_l     = exp_l;
        s1_next.man_l     = man_l;
        s1_next.man_s     = man_s >> shift;
        if (a_zero && b_zero) begin
            s1_next.bypass      = 1'b1;
            s1_next.bypass_word = '0;
        end else if (a_zero) begin
            s1_next.bypass      = 1'b1;
            s1_next.bypass_word = {b_sign_eff, b[W-2:0]};
        end else if (b_zero) begin
            s1_next.bypass      = 1'b1;
            s1_next.bypass_word = a;
        end
    end

    // Stage 2: magnitude add or subtract; L >= S so the difference never goes negative.
    always_comb begin
        s2_next             = '0;
        s2_next.sign        = s1_q.sign;
        s2_next.bypass      = s1_q.bypass;
        s2_next.bypass_word = s1_q.bypass_word;
        s2_next.exp_c       = {1'b0, s1_q.exp_l};
        if (s1_q.eff_sub) begin
            s2_next.sum = {1'b0, s1_q.man_l} - {1'b0, s1_q.man_s};
        end else begin
            s2_next.sum = {1'b0, s1_q.man_l} + {1'b0, s1_q.man_s};
        end
    end

    // Stage 3: normalize, then apply zero, underflow and overflow rules.
    always_comb begin
        lz       = lzc24(s2_q.sum[MW-1:0]);
        norm_man = s2_q.sum[MW-2:0] << lz;
        exp_dec  = {1'b0, s2_q.exp_c} - 10'(lz);
        exp_inc  = s2_q.exp_c + 9'd1;
        z_next   = '0;
        if (s2_q.bypass) begin
            z_next = s2_q.bypass_word;
        end else if (s2_q.sum == '0) begin
            z_next = '0;
        end else if (s2_q.sum[MW]) begin
            if (exp_inc[EW]) begin
                z_next = '1;
            end else begin
                z_next = {s2_q.sign, exp_inc[EW-1:0], s2_q.sum[MW-1:1]};
            end
        end else if (exp_dec[EW+1:EW] != 2'b00) begin
            z_next = '0;
        end else begin
            z_next = {s2_q.sign, exp_dec[EW-1:0], norm_man};
        end
    end

    // Pipeline registers: all stages step on en; z only loads when a result arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            z         <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s1_q      <= s1_next;
            s2_valid  <= s1_valid;
            s2_q      <= s2_next;
            out_valid <= s2_valid;
            if (s2_valid) begin
                z <= z_next;
            end
        end
    end

endmodule

// File: tb/tb_sradd_pipe.sv
// tb_sradd_pipe: directed and randomized checks of sradd_pipe against an arithmetic reference.

module tb_sradd_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z;

    sradd_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          exp_rdy = -1;
    logic        chk_lat = 1'b0;
    logic        use_dir = 1'b0;
    logic [31:0] dir_exp = '0;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    // Reference: value-level add with hidden ones, alignment, truncation and range rules.
    function automatic logic [31:0] ref_add(input logic [31:0] ra, input logic [31:0] rb, input logic rsub);
        logic   sa, sb, sl, ss;
        int     ea, eb, el, es, e, d;
        longint ma, mb, ml, ms, s;
        logic [31:0] res;
        sa = ra[31];
        sb = rb[31] ^ rsub;
        if (ra == 0 && rb == 0) return 32'h0;
        if (ra == 0) return {sb, rb[30:0]};
        if (rb == 0) return ra;
        ea = int'(ra[30:23]);
        eb = int'(rb[30:23]);
        ma = longint'(ra[22:0]) + 64'd8388608;
        mb = longint'(rb[22:0]) + 64'd8388608;
        if (ra[30:0] >= rb[30:0]) begin
            sl = sa; ss = sb; el = ea; es = eb; ml = ma; ms = mb;
        end else begin
            sl = sb; ss = sa; el = eb; es = ea; ml = mb; ms = ma;
        end
        d  = el - es;
        ms = (d >= 24) ? 0 : (ms >> d);
        s  = (sl == ss) ? (ml + ms) : (ml - ms);
        if (s == 0) return 32'h0;
        e = el;
        if (s >= 64'd16777216) begin
            s = s >> 1;
            e = e + 1;
            if (e > 255) return 32'hFFFFFFFF;
        end else begin
            while (s < 64'd8388608) begin
                s = s << 1;
                e = e - 1;
            end
        end
        if (e < 0) return 32'h0;
        res = {sl, e[7:0], s[22:0]};
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check any pop against the scoreboard, record any push.
    task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic ordy);
        logic [31:0] e;
        int          t;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        out_ready = ordy;
        #1;
        if (exp_rdy >= 0) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                t = acc_q.pop_front();
                chk("z", z, e);
                if (chk_lat) chk("latency", 32'(cyc - t), 32'd3);
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(use_dir ? dir_exp : ref_add(ia, ib, isub));
            acc_q.push_back(cyc);
            n_acc++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_dir(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                           input logic [31:0] e);
        use_dir = 1'b1;
        dir_exp = e;
        chk_lat = 1'b1;
        cycle(1'b1, ia, ib, isub, 1'b1);
        use_dir = 1'b0;
        repeat (4) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("dir_drained", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic rnd_pair(output logic [31:0] ra, output logic [31:0] rb, output logic rs);
        logic [31:0] t;
        logic [7:0]  ex;
        int          mode;
        mode = int'($urandom_range(0, 7));
        ra   = $urandom();
        rb   = $urandom();
        rs   = 1'($urandom_range(0, 1));
        t    = $urandom();
        case (mode)
            3, 4: begin
                ex = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
                rb = {t[31], ex, t[22:0]};
            end
            5: rb = {t[0], ra[30:0]};
            6: begin
                if (t[1]) ra = 32'h0;
                else      rb = 32'h0;
            end
            7: begin
                ra = {ra[31], 8'($urandom_range(0, 3)), ra[22:0]};
                rb = {rb[31], 8'($urandom_range(0, 3)), t[22:0]};
            end
            default: ;
        endcase
    endtask

    logic [31:0] pa[5];
    logic [31:0] pb[5];
    logic [31:0] ra, rb, first_exp;
    logic        rs;
    int          idx;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_z", z, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;

        // Basic add with exact 3-cycle latency and a single-cycle result
        use_dir = 1'b1;
        dir_exp = 32'h40000000;
        chk_lat = 1'b1;
        cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
        use_dir = 1'b0;
        chk("basic_lat1", 32'(out_valid), 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("basic_lat2", 32'(out_valid), 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("basic_lat3", 32'(out_valid), 32'h1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("basic_one_shot", 32'(out_valid), 32'h0);

        // Cancellation, zero operands, alignment, truncation and range limits
        run_dir(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000);
        run_dir(32'h00000000, 32'h40400000, 1'b1, 32'hC0400000);
        run_dir(32'hBF800000, 32'h00000000, 1'b0, 32'hBF800000);
        run_dir(32'h00000000, 32'h00000000, 1'b1, 32'h00000000);
        run_dir(32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000);
        run_dir(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        run_dir(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b0, 32'h407FFFFF);
        run_dir(32'h7F800000, 32'h7F800000, 1'b0, 32'hFFFFFFFF);
        run_dir(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000);
        run_dir(32'h00800001, 32'h00800000, 1'b1, 32'h00000000);
        run_dir(32'h40400000, 32'h40000000, 1'b1, 32'h3F800000);
        run_dir(32'h40000000, 32'h40400000, 1'b1, 32'hBF800000);

        // Backpressure: five pairs offered with the consumer stalled
        chk_lat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rnd_pair(pa[i], pb[i], rs);
        end
        first_exp = ref_add(pa[0], pb[0], 1'b0);
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i < 3) ? 1 : 0;
            idx = (n_acc < 5) ? n_acc : 0;
            cycle(1'b1, pa[idx], pb[idx], 1'b0, 1'b0);
            if (i >= 2) begin
                chk("bp_hold_valid", 32'(out_valid), 32'h1);
                chk("bp_hold_z", z, first_exp);
            end
        end
        exp_rdy = -1;
        chk("bp_accepted", 32'(n_acc), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_stream_valid", 32'(out_valid), 32'h1);
            idx = (n_acc < 5) ? n_acc : 0;
            cycle(n_acc < 5, pa[idx], pb[idx], 1'b0, 1'b1);
        end
        chk("bp_accepted_all", 32'(n_acc), 32'd5);
        chk("bp_drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset with two pairs in flight
        use_dir = 1'b1;
        dir_exp = 32'h40000000;
        cycle(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        dir_exp = 32'h40400000;
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        use_dir = 1'b0;
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_z", z, 32'h0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_idle", 32'(out_valid), 32'h0);
            cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        run_dir(32'h40400000, 32'h40000000, 1'b1, 32'h3F800000);

        // Random traffic with random handshakes
        chk_lat = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rnd_pair(ra, rb, rs);
            cycle($urandom_range(0, 3) != 0, ra, rb, rs, $urandom_range(0, 3) != 0);
        end
        repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("rnd_drained", 32'(exp_q.size()), 32'h0);

        // Random traffic with a free-running consumer: latency stays at 3
        chk_lat = 1'b1;
        for (int i = 0; i < 150; i++) begin
            rnd_pair(ra, rb, rs);
            cycle($urandom_range(0, 3) != 0, ra, rb, rs, 1'b1);
        end
        repeat (6) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("final_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
